// File: rtl/mul_pipeline.sv
// Four-stage integer multiply unit fed by decode; returns product[DATA_WIDTH-1:0] to writeback.
// Per-stage valid/rd are exported for hazard detection, plus a one-cycle-ahead writeback warning.
package params_pkg;
    parameter int unsigned DATA_WIDTH     = 32;
    parameter int unsigned ADDR_WIDTH     = 32;
    parameter int unsigned REGISTER_WIDTH = 5;
endpackage

module mul_pipeline #(
    parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
    parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic                      valid_i,
    input  logic [REGISTER_WIDTH-1:0] rd_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic                      wb_is_next_cycle_o,
    output logic                      wb_valid_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o
`ifndef SYNTHESIS
    ,
    output logic [ADDR_WIDTH-1:0]     debug_pc_o
`endif
);

    localparam int unsigned H = DATA_WIDTH / 2;

    // ex1: captured operands
    logic                      ex1_valid_q, ex1_valid_d;
    logic [REGISTER_WIDTH-1:0] ex1_rd_q,    ex1_rd_d;
    logic [ADDR_WIDTH-1:0]     ex1_pc_q,    ex1_pc_d;
    logic [DATA_WIDTH-1:0]     ex1_a_q,     ex1_a_d;
    logic [DATA_WIDTH-1:0]     ex1_b_q,     ex1_b_d;

    // ex2: partial products
    logic                      ex2_valid_q, ex2_valid_d;
    logic [REGISTER_WIDTH-1:0] ex2_rd_q,    ex2_rd_d;
    logic [ADDR_WIDTH-1:0]     ex2_pc_q,    ex2_pc_d;
    logic [DATA_WIDTH-1:0]     ex2_ll_q,    ex2_ll_d;
    logic [H-1:0]              ex2_lh_q,    ex2_lh_d;
    logic [H-1:0]              ex2_hl_q,    ex2_hl_d;

    // ex3: folded cross term and low product
    logic                      ex3_valid_q, ex3_valid_d;
    logic [REGISTER_WIDTH-1:0] ex3_rd_q,    ex3_rd_d;
    logic [ADDR_WIDTH-1:0]     ex3_pc_q,    ex3_pc_d;
    logic [H-1:0]              ex3_cross_q, ex3_cross_d;
    logic [DATA_WIDTH-1:0]     ex3_lo_q,    ex3_lo_d;

    // ex4: final result
    logic                      ex4_valid_q,  ex4_valid_d;
    logic [REGISTER_WIDTH-1:0] ex4_rd_q,     ex4_rd_d;
    logic [ADDR_WIDTH-1:0]     ex4_pc_q,     ex4_pc_d;
    logic [DATA_WIDTH-1:0]     ex4_result_q, ex4_result_d;

    logic [H-1:0] a_lo, a_hi, b_lo, b_hi;

    always_comb begin
        a_lo = ex1_a_q[H-1:0];
        a_hi = ex1_a_q[DATA_WIDTH-1:H];
        b_lo = ex1_b_q[H-1:0];
        b_hi = ex1_b_q[DATA_WIDTH-1:H];

        ex1_valid_d  = ex1_valid_q;
        ex1_rd_d     = ex1_rd_q;
        ex1_pc_d     = ex1_pc_q;
        ex1_a_d      = ex1_a_q;
        ex1_b_d      = ex1_b_q;
        ex2_valid_d  = ex2_valid_q;
        ex2_rd_d     = ex2_rd_q;
        ex2_pc_d     = ex2_pc_q;
        ex2_ll_d     = ex2_ll_q;
        ex2_lh_d     = ex2_lh_q;
        ex2_hl_d     = ex2_hl_q;
        ex3_valid_d  = ex3_valid_q;
        ex3_rd_d     = ex3_rd_q;
        ex3_pc_d     = ex3_pc_q;
        ex3_cross_d  = ex3_cross_q;
        ex3_lo_d     = ex3_lo_q;
        ex4_valid_d  = ex4_valid_q;
        ex4_rd_d     = ex4_rd_q;
        ex4_pc_d     = ex4_pc_q;
        ex4_result_d = ex4_result_q;

        if (!hold_i) begin
            ex1_valid_d  = valid_i;
            ex1_rd_d     = rd_i;
            ex1_pc_d     = pc_i;
            ex1_a_d      = rs1_data_i;
            ex1_b_d      = rs2_data_i;

            ex2_valid_d  = ex1_valid_q;
            ex2_rd_d     = ex1_rd_q;
            ex2_pc_d     = ex1_pc_q;
            ex2_ll_d     = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
            // Cross terms only feed bits [DATA_WIDTH-1:H], so H-bit truncation is exact.
            ex2_lh_d     = a_lo * b_hi;
            ex2_hl_d     = a_hi * b_lo;

            ex3_valid_d  = ex2_valid_q;
            ex3_rd_d     = ex2_rd_q;
            ex3_pc_d     = ex2_pc_q;
            ex3_cross_d  = ex2_lh_q + ex2_hl_q;
            ex3_lo_d     = ex2_ll_q;

            ex4_valid_d  = ex3_valid_q;
            ex4_rd_d     = ex3_rd_q;
            ex4_pc_d     = ex3_pc_q;
            ex4_result_d = ex3_lo_q + {ex3_cross_q, {H{1'b0}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex1_valid_q  <= 1'b0;
            ex1_rd_q     <= '0;
            ex1_pc_q     <= '0;
            ex1_a_q      <= '0;
            ex1_b_q      <= '0;
            ex2_valid_q  <= 1'b0;
            ex2_rd_q     <= '0;
            ex2_pc_q     <= '0;
            ex2_ll_q     <= '0;
            ex2_lh_q     <= '0;
            ex2_hl_q     <= '0;
            ex3_valid_q  <= 1'b0;
            ex3_rd_q     <= '0;
            ex3_pc_q     <= '0;
            ex3_cross_q  <= '0;
            ex3_lo_q     <= '0;
            ex4_valid_q  <= 1'b0;
            ex4_rd_q     <= '0;
            ex4_pc_q     <= '0;
            ex4_result_q <= '0;
        end else begin
            ex1_valid_q  <= ex1_valid_d;
            ex1_rd_q     <= ex1_rd_d;
            ex1_pc_q     <= ex1_pc_d;
            ex1_a_q      <= ex1_a_d;
            ex1_b_q      <= ex1_b_d;
            ex2_valid_q  <= ex2_valid_d;
            ex2_rd_q     <= ex2_rd_d;
            ex2_pc_q     <= ex2_pc_d;
            ex2_ll_q     <= ex2_ll_d;
            ex2_lh_q     <= ex2_lh_d;
            ex2_hl_q     <= ex2_hl_d;
            ex3_valid_q  <= ex3_valid_d;
            ex3_rd_q     <= ex3_rd_d;
            ex3_pc_q     <= ex3_pc_d;
            ex3_cross_q  <= ex3_cross_d;
            ex3_lo_q     <= ex3_lo_d;
            ex4_valid_q  <= ex4_valid_d;
            ex4_rd_q     <= ex4_rd_d;
            ex4_pc_q     <= ex4_pc_d;
            ex4_result_q <= ex4_result_d;
        end
    end

    assign ex1_valid_o  = ex1_valid_q;
    assign ex2_valid_o  = ex2_valid_q;
    assign ex3_valid_o  = ex3_valid_q;
    assign ex4_valid_o  = ex4_valid_q;
    assign ex1_wr_reg_o = ex1_rd_q;
    assign ex2_wr_reg_o = ex2_rd_q;
    assign ex3_wr_reg_o = ex3_rd_q;
    assign ex4_wr_reg_o = ex4_rd_q;

    assign wb_is_next_cycle_o = ex3_valid_q & ~hold_i;
    assign wb_valid_o         = ex4_valid_q;
    assign wb_wr_reg_o        = ex4_rd_q;
    assign wb_data_o          = ex4_result_q;

`ifndef SYNTHESIS
    assign debug_pc_o = ex4_pc_q;
`endif

endmodule

// File: tb/tb_mul_pipeline.sv
// Directed and randomized checks of mul_pipeline against a slot-per-stage model
// whose products come from plain 64-bit multiplication.
module tb_mul_pipeline;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        hold_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o;
    logic [4:0]  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o;
    logic        wb_is_next_cycle_o, wb_valid_o;
    logic [4:0]  wb_wr_reg_o;
    logic [31:0] wb_data_o;
    logic [31:0] debug_pc_o;

    int n_vec = 0;
    int n_err = 0;

    // model: one slot per stage, index 0 = ex1
    logic        m_valid [4];
    logic [4:0]  m_rd    [4];
    logic [31:0] m_pc    [4];
    logic [31:0] m_prod  [4];

    mul_pipeline #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .REGISTER_WIDTH(5)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .hold_i            (hold_i),
        .valid_i           (valid_i),
        .rd_i              (rd_i),
        .pc_i              (pc_i),
        .rs1_data_i        (rs1_data_i),
        .rs2_data_i        (rs2_data_i),
        .ex1_valid_o       (ex1_valid_o),
        .ex2_valid_o       (ex2_valid_o),
        .ex3_valid_o       (ex3_valid_o),
        .ex4_valid_o       (ex4_valid_o),
        .ex1_wr_reg_o      (ex1_wr_reg_o),
        .ex2_wr_reg_o      (ex2_wr_reg_o),
        .ex3_wr_reg_o      (ex3_wr_reg_o),
        .ex4_wr_reg_o      (ex4_wr_reg_o),
        .wb_is_next_cycle_o(wb_is_next_cycle_o),
        .wb_valid_o        (wb_valid_o),
        .wb_wr_reg_o       (wb_wr_reg_o),
        .wb_data_o         (wb_data_o)
`ifndef SYNTHESIS
        ,
        .debug_pc_o        (debug_pc_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] ev;
        logic [4:0] er [4];
        ev = {ex4_valid_o, ex3_valid_o, ex2_valid_o, ex1_valid_o};
        er[0] = ex1_wr_reg_o; er[1] = ex2_wr_reg_o; er[2] = ex3_wr_reg_o; er[3] = ex4_wr_reg_o;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ex%0d_valid", i + 1), 64'(ev[i]), 64'(m_valid[i]));
            if (m_valid[i]) check($sformatf("ex%0d_wr_reg", i + 1), 64'(er[i]), 64'(m_rd[i]));
        end
        check("wb_valid", 64'(wb_valid_o), 64'(m_valid[3]));
        if (m_valid[3]) begin
            check("wb_wr_reg", 64'(wb_wr_reg_o), 64'(m_rd[3]));
            check("wb_data", 64'(wb_data_o), 64'(m_prod[3]));
`ifndef SYNTHESIS
            check("debug_pc", 64'(debug_pc_o), 64'(m_pc[3]));
`endif
        end
    endtask

    // Apply one cycle of inputs, check the combinational warning, clock, update model, check state.
    task automatic tick(input logic r, input logic h, input logic v, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        rst_i = r; hold_i = h; valid_i = v; rd_i = rd; pc_i = pc; rs1_data_i = a; rs2_data_i = b;
        #1;
        check("wb_is_next_cycle", 64'(wb_is_next_cycle_o), 64'(m_valid[2] & ~h));
        @(posedge clk_i);
        if (r) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        end else if (!h) begin
            for (int i = 3; i > 0; i--) begin
                m_valid[i] = m_valid[i-1]; m_rd[i] = m_rd[i-1];
                m_pc[i] = m_pc[i-1]; m_prod[i] = m_prod[i-1];
            end
            full = {32'd0, a} * {32'd0, b};
            m_valid[0] = v; m_rd[0] = rd; m_pc[0] = pc; m_prod[0] = full[31:0];
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic single_mul(input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic [31:0] exp);
        tick(1'b0, 1'b0, 1'b1, rd, 32'h100, a, b);
        idle(3);
        check("directed_wb_valid", 64'(wb_valid_o), 64'd1);
        check("directed_wb_data", 64'(wb_data_o), 64'(exp));
        check("directed_wb_rd", 64'(wb_wr_reg_o), 64'(rd));
        idle(1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0; m_rd[i] = '0; m_pc[i] = '0; m_prod[i] = '0;
        end

        // reset, with hold and valid asserted to show reset wins
        tick(1'b1, 1'b1, 1'b1, 5'd9, 32'd0, 32'd3, 32'd3);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("reset_valids", 64'({ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, wb_valid_o}), 64'd0);
        check("reset_wb_next", 64'(wb_is_next_cycle_o), 64'd0);

        // single MUL, then wrap cases
        tick(1'b0, 1'b0, 1'b1, 5'd5, 32'h40, 32'd7, 32'd6);
        idle(1);
        idle(1);
        check("single_wb_next_c3", 64'(wb_is_next_cycle_o), 64'd1);
        idle(1);
        check("single_wb_data", 64'(wb_data_o), 64'd42);
        check("single_wb_rd", 64'(wb_wr_reg_o), 64'd5);
        idle(1);
        check("single_drained", 64'(wb_valid_o), 64'd0);

        single_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
        single_mul(32'h8000_0000, 32'd2,         5'd2, 32'h0000_0000);
        single_mul(32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000);
        single_mul(32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 32'h242D_2080);

        // back-to-back
        for (int i = 1; i <= 4; i++)
            tick(1'b0, 1'b0, 1'b1, 5'(i), 32'(i * 4), 32'(i + 10), 32'(i * 3));
        check("b2b_all_valid", 64'({ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o}), 64'hF);
        check("b2b_first_rd", 64'(wb_wr_reg_o), 64'd1);
        idle(3);
        check("b2b_last_rd", 64'(wb_wr_reg_o), 64'd4);
        check("b2b_last_data", 64'(wb_data_o), 64'd168);
        idle(2);

        // hold while in ex2, with valid_i pulsed during hold
        tick(1'b0, 1'b0, 1'b1, 5'd7, 32'h200, 32'd11, 32'd13);
        idle(1);
        tick(1'b0, 1'b1, 1'b1, 5'd8, 32'h204, 32'd2, 32'd2);
        tick(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 5'd9, 32'h208, 32'd3, 32'd3);
        check("hold_ex1_not_captured", 64'(ex1_valid_o), 64'd0);
        check("hold_ex2_frozen", 64'({ex2_valid_o, ex2_wr_reg_o}), 64'({1'b1, 5'd7}));
        idle(1);
        // now in ex3: hold again, warning must be suppressed
        tick(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("hold_ex3_no_wb_next", 64'(wb_is_next_cycle_o), 64'd0);
        idle(1);
        check("hold_late_result", 64'(wb_data_o), 64'd143);
        tick(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("hold_wb_repeat", 64'(wb_valid_o), 64'd1);
        idle(2);

        // reset mid-flight
        tick(1'b0, 1'b0, 1'b1, 5'd12, 32'h300, 32'd5, 32'd5);
        tick(1'b0, 1'b0, 1'b1, 5'd13, 32'h304, 32'd6, 32'd6);
        idle(1);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("midreset_valids", 64'({ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o}), 64'd0);
        idle(5);

        // random regression
        for (int n = 0; n < 10000; n++)
            tick(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                 5'($urandom), $urandom, $urandom, $urandom);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_pipeline.md
Name: mul_pipeline

Overview:
- Four-stage integer multiply unit directly downstream of the decode stage.
- Consumes decoded MUL instructions: the decode-issued valid, destination register and bypassed rs1/rs2 operands.
- Exposes per-stage valid and destination register back to decode for hazard stalls, plus a one-cycle-ahead writeback warning.
- Presents the 32-bit product to the writeback stage.

Parameters:
- DATA_WIDTH, params_pkg::DATA_WIDTH (32), operand/result width; must be even.
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, PC width, carried for debug and trace.
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5), register index width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- hold_i  in  1  freeze every stage (memory stall).
- valid_i  in  1  MUL issued from decode this cycle.
- rd_i  in  REGISTER_WIDTH  destination register.
- pc_i  in  ADDR_WIDTH  PC of the issued MUL.
- rs1_data_i  in  DATA_WIDTH  operand A.
- rs2_data_i  in  DATA_WIDTH  operand B.
- ex1_valid_o..ex4_valid_o  out  1 each  stage occupancy.
- ex1_wr_reg_o..ex4_wr_reg_o  out  REGISTER_WIDTH each  stage destination.
- wb_is_next_cycle_o  out  1  ex4 will present a result next cycle.
- wb_valid_o  out  1  result valid this cycle.
- wb_wr_reg_o  out  REGISTER_WIDTH  result destination.
- wb_data_o  out  DATA_WIDTH  product[DATA_WIDTH-1:0].
- debug_pc_o  out  ADDR_WIDTH  PC at ex4; present only under `ifndef SYNTHESIS.

Behaviour:
- Reset (rst_i=1 at a posedge): all exN_valid_o=0, wb_valid_o=0, wb_is_next_cycle_o=0.
  - Data, wr_reg and pc registers are don't-care but must not produce X on outputs gated by valid.
  - Reset overrides hold_i and valid_i, including mid-operation: in-flight products are discarded.
- Let H = DATA_WIDTH/2, and split each operand into low/high halves: aL, aH, bL, bH.
- Stage datapath, advancing on every posedge with hold_i=0:
  - ex1 captures valid_i, rd_i, pc_i and the operands.
  - ex2 holds the three partial products aL*bL (2H bits), aL*bH and aH*bL (each truncated to H bits).
  - ex3 holds cross = (aL*bH + aH*bL) mod 2^H and lo = aL*bL.
  - ex4 holds result = lo + (cross << H), modulo 2^DATA_WIDTH.
  - aH*bH is never computed.
- Signedness: the low DATA_WIDTH bits are identical for signed and unsigned, so there is no sign handling.
- Latency: valid_i sampled at edge k → ex1_valid_o=1 after k, ex4 after k+3, so wb_valid_o is high during the cycle following edge k+3.
- Throughput: one MUL per cycle, back-to-back, with no bubbles required.
- Outputs:
  - wb_valid_o = ex4_valid_o; wb_wr_reg_o = ex4_wr_reg_o; wb_data_o = ex4 result. All are registered outputs with no combinational input path.
  - wb_is_next_cycle_o = ex3_valid_o & ~hold_i (combinational). Decode uses it to stall an ALU op that would collide at writeback.
- hold_i=1: every stage register, including valid bits, keeps its value.
  - valid_i is ignored (decode is also stalled).
  - wb_valid_o stays asserted for as long as ex4 is held; writeback must treat repeated writes of the same reg/data as idempotent.
- A stage whose valid bit is 0 shifts 0 into the next stage's valid. Data registers may update freely.
- ex4 drains unconditionally when hold_i=0: writeback always accepts multiply results, and there is no backpressure other than hold_i.
- Simultaneous valid_i and hold_i: hold wins and the instruction is not captured.
- Simultaneous rst_i and hold_i: reset wins.

Test Plan:
- Single MUL: rs1=7, rs2=6, rd=5 at cycle 0 → ex1..ex4_valid_o pulse in cycles 1..4; cycle 4 shows wb_valid_o=1, wb_wr_reg_o=5, wb_data_o=42; wb_is_next_cycle_o=1 in cycle 3 only.
- Wrap/signed: 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001; 0x80000000 × 2 → 0x00000000; 0x0001_0000 × 0x0001_0000 → 0; 0x1234_5678 × 0x9ABC_DEF0 → 0x242D_2080.
- Back-to-back: four MULs on consecutive cycles (rd=1..4) → all four exN_valid_o high in cycle 4, results emerge on cycles 4..7 in order, each with the correct rd.
- Hold: issue a MUL, assert hold_i for 3 cycles while it sits in ex2 → ex2 values frozen, valid_i pulsed during the hold is not captured, result appears 3 cycles late, wb_is_next_cycle_o=0 while held in ex3.
- Reset mid-flight: two MULs in ex2/ex3, rst_i=1 for one cycle → all valid outputs 0 the next cycle, and no wb_valid_o ever appears for them.
- Random regression: 10k random operands with random hold_i and valid_i → every wb result equals (a*b) mod 2^32 with the matching rd and pc; no result is lost or duplicated apart from held repeats.
